// File: rtl/branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_pkg : branch op encoding, default sizes, direction evaluator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_resolve_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    BEQ = 2'b00,
    BNE = 2'b01,
    BLT = 2'b10,
    BGE = 2'b11
  } br_op_e;

  function automatic logic branch_taken(input br_op_e op, input logic [3:0] a, input logic [3:0] b);
    logic taken;
    case (op)
      BEQ:     taken = (a == b);
      BNE:     taken = (a != b);
      BLT:     taken = (a < b);
      default: taken = (a >= b);
    endcase
    return taken;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pred_fifo.sv
// ---------------------------------------------------------------------------
// pred_fifo : 1-bit circular prediction queue with single-edge flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pred_fifo
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when a slot frees on the same edge.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve : resolves branches against queued predictions, flags, stats
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic             pred_taken_i,
  input  logic             res_valid_i,
  input  logic [1:0]       op_i,
  input  logic [3:0]       a_i,
  input  logic [3:0]       b_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             mispredict_o,
  output logic             actual_taken_o,
  output logic             resolved_ok_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic             head_pred, actual, pop, mis, push;
  logic             mispredict_q, actual_taken_q, resolved_ok_q, overflow_q, underflow_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  assign actual = branch_taken(br_op_e'(op_i), a_i, b_i);
  assign pop    = res_valid_i && !empty_o;
  assign mis    = pop && (actual != head_pred);
  // Pushes arriving with a mispredict are wrong-path and silently discarded.
  assign push   = pred_valid_i && !mis;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (mis),
    .din_i   (pred_taken_i),
    .dout_o  (head_pred),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign branch_cnt_d  = (pop && branch_cnt_q != '1)  ? branch_cnt_q + 1'b1  : branch_cnt_q;
  assign mispred_cnt_d = (mis && mispred_cnt_q != '1) ? mispred_cnt_q + 1'b1 : mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q   <= 1'b0;
      actual_taken_q <= 1'b0;
      resolved_ok_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      branch_cnt_q   <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      resolved_ok_q <= pop;
      mispredict_q  <= mis;
      if (pop) actual_taken_q <= actual;
      if (pred_valid_i && full_o && !pop) overflow_q <= 1'b1;
      if (res_valid_i && empty_o) underflow_q <= 1'b1;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict_o   = mispredict_q;
  assign actual_taken_o = actual_taken_q;
  assign resolved_ok_o  = resolved_ok_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;
  assign branch_cnt_o   = branch_cnt_q;
  assign mispred_cnt_o  = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve : directed self-checking bench for branch_resolve
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, res_valid;
  logic [1:0] op;
  logic [3:0] a, b;
  logic       full, empty, mispredict, actual_taken, resolved_ok, overflow, underflow;
  logic [7:0] branch_cnt, mispred_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  branch_resolve #(.DEPTH(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid_i   (pred_valid),
    .pred_taken_i   (pred_taken),
    .res_valid_i    (res_valid),
    .op_i           (op),
    .a_i            (a),
    .b_i            (b),
    .full_o         (full),
    .empty_o        (empty),
    .mispredict_o   (mispredict),
    .actual_taken_o (actual_taken),
    .resolved_ok_o  (resolved_ok),
    .overflow_o     (overflow),
    .underflow_o    (underflow),
    .branch_cnt_o   (branch_cnt),
    .mispred_cnt_o  (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    pred_taken = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
    rst_n = 1'b0;
    #12;
    total_cnt++; if ({empty, full} !== 2'b10) $display("FAIL reset_status: got %b expected 10", {empty, full}); else pass_cnt++;
    total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {resolved_ok, mispredict, actual_taken}); else pass_cnt++;
    total_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); else pass_cnt++;
    total_cnt++; if ({branch_cnt, mispred_cnt} !== 16'h0000) $display("FAIL reset_counters: got %h expected 0000", {branch_cnt, mispred_cnt}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct();
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b10};
    logic [3:0] as  [3] = '{4'd5, 4'd3, 4'd2};
    logic [3:0] bs  [3] = '{4'd5, 4'd3, 4'd9};
    logic       exp [3] = '{1'b1, 1'b0, 1'b1};
    pred_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pred_taken = exp[i];
      step();
    end
    pred_valid = 1'b0;
    total_cnt++; if ({empty, full} !== 2'b00) $display("FAIL correct_fill: got %b expected 00", {empty, full}); else pass_cnt++;
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; a = as[i]; b = bs[i];
      step();
      total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== {2'b10, exp[i]}) $display("FAIL correct_resolve%0d: got %b expected %b", i, {resolved_ok, mispredict, actual_taken}, {2'b10, exp[i]}); else pass_cnt++;
    end
    res_valid = 1'b0;
    total_cnt++; if ({empty, branch_cnt, mispred_cnt} !== {1'b1, 8'd3, 8'd0}) $display("FAIL correct_stats: got %h expected %h", {empty, branch_cnt, mispred_cnt}, {1'b1, 8'd3, 8'd0}); else pass_cnt++;
    step();
    total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== 3'b001) $display("FAIL correct_idle_hold: got %b expected 001", {resolved_ok, mispredict, actual_taken}); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    pred_valid = 1'b1; pred_taken = 1'b1;
    repeat (3) step();
    pred_valid = 1'b0;
    res_valid = 1'b1; op = 2'b11; a = 4'd2; b = 4'd7;
    step();
    res_valid = 1'b0;
    total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== 3'b110) $display("FAIL mis_pulse: got %b expected 110", {resolved_ok, mispredict, actual_taken}); else pass_cnt++;
    total_cnt++; if ({empty, branch_cnt, mispred_cnt} !== {1'b1, 8'd4, 8'd1}) $display("FAIL mis_flush_stats: got %h expected %h", {empty, branch_cnt, mispred_cnt}, {1'b1, 8'd4, 8'd1}); else pass_cnt++;
    step();
    total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== 3'b000) $display("FAIL mis_pulse_end: got %b expected 000", {resolved_ok, mispredict, actual_taken}); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic       preds [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] as  [4] = '{4'd0, 4'd4, 4'd9, 4'd7};
    logic [3:0] bs  [4] = '{4'd0, 4'd4, 4'd2, 4'd7};
    pred_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pred_taken = preds[i];
      step();
      if (i == 3) begin
        total_cnt++; if ({full, overflow} !== 2'b10) $display("FAIL ovf_full4: got %b expected 10", {full, overflow}); else pass_cnt++;
      end
    end
    pred_valid = 1'b0;
    total_cnt++; if ({full, overflow} !== 2'b11) $display("FAIL ovf_set: got %b expected 11", {full, overflow}); else pass_cnt++;
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = ops[i]; a = as[i]; b = bs[i];
      step();
      total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== {2'b10, preds[i]}) $display("FAIL ovf_drain%0d: got %b expected %b", i, {resolved_ok, mispredict, actual_taken}, {2'b10, preds[i]}); else pass_cnt++;
    end
    res_valid = 1'b0;
    total_cnt++; if ({empty, branch_cnt, mispred_cnt} !== {1'b1, 8'd8, 8'd1}) $display("FAIL ovf_stats: got %h expected %h", {empty, branch_cnt, mispred_cnt}, {1'b1, 8'd8, 8'd1}); else pass_cnt++;
  endtask

  task automatic test_underflow();
    res_valid = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
    step();
    res_valid = 1'b0;
    total_cnt++; if ({underflow, resolved_ok, mispredict} !== 3'b100) $display("FAIL udf_flags: got %b expected 100", {underflow, resolved_ok, mispredict}); else pass_cnt++;
    total_cnt++; if ({branch_cnt, mispred_cnt} !== {8'd8, 8'd1}) $display("FAIL udf_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {8'd8, 8'd1}); else pass_cnt++;
    step();
    total_cnt++; if ({underflow, overflow} !== 2'b11) $display("FAIL sticky_flags: got %b expected 11", {underflow, overflow}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    total_cnt++; if ({overflow, underflow, empty} !== 3'b001) $display("FAIL b2b_reset: got %b expected 001", {overflow, underflow, empty}); else pass_cnt++;
    pred_valid = 1'b1; pred_taken = 1'b1;
    repeat (4) step();
    pred_taken = 1'b0;
    res_valid = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
    step();
    total_cnt++; if ({full, overflow} !== 2'b10) $display("FAIL b2b_full_push_pop: got %b expected 10", {full, overflow}); else pass_cnt++;
    total_cnt++; if ({resolved_ok, mispredict, actual_taken} !== 3'b101) $display("FAIL b2b_resolve: got %b expected 101", {resolved_ok, mispredict, actual_taken}); else pass_cnt++;
    pred_taken = 1'b1; op = 2'b01;
    step();
    idle();
    total_cnt++; if ({empty, overflow, resolved_ok, mispredict, actual_taken} !== 5'b10110) $display("FAIL b2b_wrongpath: got %b expected 10110", {empty, overflow, resolved_ok, mispredict, actual_taken}); else pass_cnt++;
    total_cnt++; if ({branch_cnt, mispred_cnt} !== {8'd2, 8'd1}) $display("FAIL b2b_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {8'd2, 8'd1}); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    pred_valid = 1'b1; pred_taken = 1'b1;
    step();
    res_valid = 1'b1; op = 2'b00; a = 4'd3; b = 4'd3;
    repeat (300) step();
    total_cnt++; if ({branch_cnt, mispred_cnt} !== {8'd255, 8'd0}) $display("FAIL sat_counters: got %h expected %h", {branch_cnt, mispred_cnt}, {8'd255, 8'd0}); else pass_cnt++;
    total_cnt++; if ({resolved_ok, underflow, overflow} !== 3'b100) $display("FAIL sat_stream: got %b expected 100", {resolved_ok, underflow, overflow}); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({empty, full, resolved_ok, mispredict, actual_taken} !== 5'b10000) $display("FAIL midreset_status: got %b expected 10000", {empty, full, resolved_ok, mispredict, actual_taken}); else pass_cnt++;
    total_cnt++; if ({branch_cnt, mispred_cnt, overflow, underflow} !== 18'd0) $display("FAIL midreset_counters: got %h expected 0", {branch_cnt, mispred_cnt, overflow, underflow}); else pass_cnt++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'b1;
    step();
    pred_valid = 1'b0;
    total_cnt++; if (empty !== 1'b0) $display("FAIL post_reset_push: got empty=%b expected 0", empty); else pass_cnt++;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    total_cnt++; if ({resolved_ok, mispredict, actual_taken, branch_cnt} !== {3'b101, 8'd1}) $display("FAIL post_reset_resolve: got %h expected %h", {resolved_ok, mispredict, actual_taken, branch_cnt}, {3'b101, 8'd1}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
